// File: rtl/fdiv64_iter_if.sv
// Operand/result stream bundle between an FP divide client and the divider core.
//   master : drives dividend/divisor (data + valid), observes tready and result
//   slave  : the divider core; consumes operands, produces tready and result
interface fdiv64_iter_if;
    logic [63:0] s_axis_a_tdata;
    logic        s_axis_a_tvalid;
    logic [63:0] s_axis_b_tdata;
    logic        s_axis_b_tvalid;
    logic        s_axis_tready;
    logic [63:0] m_axis_result_tdata;
    logic        m_axis_result_tvalid;

    modport master (
        output s_axis_a_tdata, s_axis_a_tvalid,
        output s_axis_b_tdata, s_axis_b_tvalid,
        input  s_axis_tready,
        input  m_axis_result_tdata, m_axis_result_tvalid
    );

    modport slave (
        input  s_axis_a_tdata, s_axis_a_tvalid,
        input  s_axis_b_tdata, s_axis_b_tvalid,
        output s_axis_tready,
        output m_axis_result_tdata, m_axis_result_tvalid
    );
endinterface

// File: rtl/fdiv64_iter.sv
// Iterative binary64 divider: one restoring quotient bit per cycle, RNE rounding,
// subnormal inputs treated as zero, subnormal results flushed to zero.
// Fixed 56-cycle latency for every operand class, one operation in flight.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : operand/result stream (slave side); tready is high while IDLE,
//           result tvalid is a one-cycle pulse with no backpressure
module fdiv64_iter (
    input  logic         clk,
    input  logic         reset,
    fdiv64_iter_if.slave bus
);
    localparam int unsigned EW     = 11;
    localparam int unsigned FW     = 52;
    localparam int unsigned MW     = 53;
    localparam int unsigned RW     = 54;
    localparam int unsigned QW     = 55;
    localparam int unsigned XW     = 13;
    localparam int unsigned CW     = 6;
    localparam int unsigned N_ITER = 55;
    localparam int unsigned BIAS   = 1023;

    typedef enum logic [1:0] {IDLE, DIV, ROUND} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_accept;
    logic            w_iter;
    logic            w_round;

    logic            r_sign;
    logic [EW-1:0]   r_ea;
    logic [EW-1:0]   r_eb;
    logic [RW-1:0]   r_rem;
    logic [MW-1:0]   r_mb;
    logic [QW-1:0]   r_q;
    logic [CW-1:0]   r_cnt;
    logic            r_res_nan;
    logic            r_res_inf;
    logic            r_res_zero;
    logic [63:0]     r_tdata;
    logic            r_tvalid;

    // Operand classification on the live input bus
    logic [EW-1:0]   w_ea;
    logic [EW-1:0]   w_eb;
    logic [FW-1:0]   w_fa;
    logic [FW-1:0]   w_fb;
    logic            w_a_zero, w_a_inf, w_a_nan;
    logic            w_b_zero, w_b_inf, w_b_nan;

    assign w_ea     = bus.s_axis_a_tdata[62:52];
    assign w_eb     = bus.s_axis_b_tdata[62:52];
    assign w_fa     = bus.s_axis_a_tdata[FW-1:0];
    assign w_fb     = bus.s_axis_b_tdata[FW-1:0];
    assign w_a_zero = (w_ea == '0);
    assign w_b_zero = (w_eb == '0);
    assign w_a_inf  = (w_ea == '1) && (w_fa == '0);
    assign w_b_inf  = (w_eb == '1) && (w_fb == '0);
    assign w_a_nan  = (w_ea == '1) && (w_fa != '0);
    assign w_b_nan  = (w_eb == '1) && (w_fb != '0);

    assign bus.s_axis_tready        = (r_state == IDLE);
    assign bus.m_axis_result_tdata  = r_tdata;
    assign bus.m_axis_result_tvalid = r_tvalid;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state and phase strobes
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_iter      = 1'b0;
        w_round     = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.s_axis_a_tvalid && bus.s_axis_b_tvalid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = DIV;
                end
            end
            DIV: begin
                w_iter = 1'b1;
                if (r_cnt == CW'(N_ITER - 1)) w_state_nxt = ROUND;
            end
            ROUND: begin
                w_round     = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // One restoring step; the subtracted remainder is always below mb, so the shift never overflows
    logic            w_qbit;
    logic [RW-1:0]   w_rem_sub;
    logic [RW-1:0]   w_rem_nxt;

    always_comb begin
        w_qbit    = (r_rem >= RW'(r_mb));
        w_rem_sub = w_qbit ? (r_rem - RW'(r_mb)) : r_rem;
        w_rem_nxt = {w_rem_sub[RW-2:0], 1'b0};
    end

    // Normalise, round to nearest even, range-check and pick special results
    logic [MW-1:0]   w_mant;
    logic            w_guard;
    logic            w_sticky;
    logic            w_adj;
    logic            w_inc;
    logic [RW-1:0]   w_mant_rnd;
    logic [MW-1:0]   w_mant_fin;
    logic signed [XW-1:0] w_exp;
    logic signed [XW-1:0] w_exp_fin;
    logic [63:0]     w_result;

    always_comb begin
        w_mant     = '0;
        w_guard    = 1'b0;
        w_sticky   = 1'b0;
        w_adj      = 1'b0;
        w_inc      = 1'b0;
        w_mant_rnd = '0;
        w_mant_fin = '0;
        w_exp      = '0;
        w_exp_fin  = '0;
        w_result   = '0;

        if (r_q[QW-1]) begin
            w_mant   = r_q[QW-1:2];
            w_guard  = r_q[1];
            w_sticky = r_q[0] | (r_rem != '0);
            w_adj    = 1'b0;
        end else begin
            w_mant   = r_q[QW-2:1];
            w_guard  = r_q[0];
            w_sticky = (r_rem != '0);
            w_adj    = 1'b1;
        end

        w_exp      = XW'(r_ea) - XW'(r_eb) + XW'(BIAS) - XW'(w_adj);
        w_inc      = w_guard & (w_sticky | w_mant[0]);
        w_mant_rnd = {1'b0, w_mant} + RW'(w_inc);

        // Carry out of 53 bits: mantissa wraps to exactly 1.0
        if (w_mant_rnd[MW]) begin
            w_mant_fin = {1'b1, {FW{1'b0}}};
            w_exp_fin  = w_exp + XW'(1);
        end else begin
            w_mant_fin = w_mant_rnd[MW-1:0];
            w_exp_fin  = w_exp;
        end

        if (r_res_nan)
            w_result = {1'b0, {EW{1'b1}}, 1'b1, {(FW-1){1'b0}}};
        else if (r_res_inf)
            w_result = {r_sign, {EW{1'b1}}, {FW{1'b0}}};
        else if (r_res_zero)
            w_result = {r_sign, 63'd0};
        else if (w_exp_fin >= $signed(XW'(2047)))
            w_result = {r_sign, {EW{1'b1}}, {FW{1'b0}}};
        else if (w_exp_fin <= $signed(XW'(0)))
            w_result = {r_sign, 63'd0};
        else
            w_result = {r_sign, w_exp_fin[EW-1:0], w_mant_fin[FW-1:0]};
    end

    // Operand capture, iteration and result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sign     <= 1'b0;
            r_ea       <= '0;
            r_eb       <= '0;
            r_rem      <= '0;
            r_mb       <= '0;
            r_q        <= '0;
            r_cnt      <= '0;
            r_res_nan  <= 1'b0;
            r_res_inf  <= 1'b0;
            r_res_zero <= 1'b0;
            r_tdata    <= '0;
            r_tvalid   <= 1'b0;
        end else begin
            r_tvalid <= w_round;
            if (w_accept) begin
                r_sign     <= bus.s_axis_a_tdata[63] ^ bus.s_axis_b_tdata[63];
                r_ea       <= w_ea;
                r_eb       <= w_eb;
                r_rem      <= RW'({1'b1, w_fa});
                r_mb       <= {1'b1, w_fb};
                r_q        <= '0;
                r_cnt      <= '0;
                r_res_nan  <= w_a_nan | w_b_nan | (w_a_zero & w_b_zero) | (w_a_inf & w_b_inf);
                r_res_inf  <= w_a_inf | w_b_zero;
                r_res_zero <= w_a_zero | w_b_inf;
            end
            if (w_iter) begin
                r_rem <= w_rem_nxt;
                r_q   <= {r_q[QW-2:0], w_qbit};
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_round) r_tdata <= w_result;
        end
    end
endmodule
